axi_aw_decoder_ctrl: RTL and testbench
======================================

// Module: axi_aw_decoder_ctrl
// PURPOSE
//  Parametrised AW-channel address decoder for the AXI4 interconnect, one instance per target (master-side) port.
//  Decodes awaddr against N_REGION x N_INIT_PORT address windows, masks the result with the connectivity map,
//  and forwards awvalid one-hot to the matching initiator port.
//  Tracks outstanding writes internally and handles decode errors: stall/drain/sink-W/error-B, or route to a default port.
//  Sits between the master AW input and the per-slave AW arbiters, next to the W-routing DEST FIFO.
// PARAMETERS
//  ADDR_WIDTH    32  address width
//  N_INIT_PORT   8   number of initiator (slave-side) ports
//  N_REGION      2   address windows per initiator port
//  MAX_OUT       8   max outstanding forwarded writes; counter width CW=$clog2(MAX_OUT+1)
//  ERR_MODE      0   0: decode error -> internal error response; 1: route unmatched to DEFAULT_PORT
//  DEFAULT_PORT  0   initiator index used when ERR_MODE=1 (0..N_INIT_PORT-1)
// PORTS
//  clk                 in   1                    clock, all logic on rising edge
//  rst                 in   1                    synchronous, active-high reset
//  awvalid_i           in   1                    AW valid from master
//  awaddr_i            in   ADDR_WIDTH           AW address
//  awready_o           out  1                    AW ready to master
//  awvalid_o           out  N_INIT_PORT          one-hot AW valid to initiator ports
//  awready_i           in   N_INIT_PORT          AW ready from initiator ports
//  dest_ready_i        in   1                    DEST FIFO can accept an entry
//  dest_o              out  N_INIT_PORT          one-hot decoded destination
//  push_dest_o         out  1                    push dest_o into DEST FIFO
//  start_addr_i        in   N_REGION*N_INIT_PORT*ADDR_WIDTH  window start (inclusive)
//  end_addr_i          in   N_REGION*N_INIT_PORT*ADDR_WIDTH  window end (inclusive)
//  enable_region_i     in   N_REGION*N_INIT_PORT window enable
//  connectivity_map_i  in   N_INIT_PORT          1 = initiator port reachable
//  b_done_i            in   1                    one forwarded write's B handshake completed
//  wvalid_i            in   1                    W valid (used only while sinking error data)
//  wlast_i             in   1                    W last
//  wready_err_o        out  1                    W ready for error burst
//  err_bvalid_o        out  1                    error response (DECERR) valid
//  err_bready_i        in   1                    error response accepted
//  out_cnt_o           out  CW                   outstanding forwarded writes
// BEHAVIOUR
//  Reset: state OPERATIVE, out_cnt 0; all outputs 0 in the reset cycle.
//  Decode (combinational):
//   hit[i] = OR over regions of (enable & start<=addr<=end); m = hit & connectivity_map_i.
//   Multiple hits: lowest index wins, so dest_o is always one-hot or zero.
//   No hit: ERR_MODE=1 -> dest = 1<<DEFAULT_PORT; ERR_MODE=0 -> err = 1, dest_o = 0.
//  OPERATIVE, zero-cycle latency:
//   With awvalid_i, dest_ready_i, !err and out_cnt<MAX_OUT: awvalid_o=dest, awready_o=|(awready_i&dest).
//   push_dest_o = awvalid_i & awready_o & !err.
//   dest_ready_i=0 or out_cnt==MAX_OUT: awvalid_o=0, awready_o=0 (stall).
//   With awvalid_i, dest_ready_i, err: awready_o=1 for one cycle, no push, awvalid_o=0 -> DRAIN.
//  DRAIN: awready_o=0; out_cnt==0 -> SINK_W (includes the cycle out_cnt drops to 0).
//  SINK_W: wready_err_o=1; wvalid_i & wlast_i -> ERR_RESP.
//  ERR_RESP: err_bvalid_o=1, held until err_bready_i -> OPERATIVE; no AW is accepted.
//  out_cnt: +1 on forwarded AW handshake, -1 on b_done_i; both in the same cycle -> unchanged.
//   Never wraps; b_done_i at out_cnt==0 is ignored.
//  awvalid_o must not drop before handshake: decode uses awaddr_i, which the master holds stable while awvalid_i=1.
//  Reset mid-operation (any state): next cycle OPERATIVE, out_cnt 0, pending error discarded.
// TESTING
//  1 Region 0 of port 2 = 0x1000-0x1FFF; awaddr 0x1800, awready_i[2]=1 -> awvalid_o=0x04, awready_o=1, push_dest_o=1 same cycle, out_cnt 0->1.
//  2 Ports 1 and 3 overlap at 0x2000 -> dest_o=0x02 only; connectivity_map_i[1]=0 -> dest_o=0x08.
//  3 MAX_OUT=2, two forwarded AWs without b_done_i -> third AW stalls (awready_o=0); b_done_i pulse -> accepted next cycle.
//  4 ERR_MODE=0, awaddr 0xF000 unmapped, out_cnt=1 -> awready_o 1 cycle, stays in DRAIN until b_done_i;
//    then 4 W beats (last with wlast) sunk; err_bvalid_o held 3 cycles until err_bready_i.
//  5 ERR_MODE=1, DEFAULT_PORT=5, unmapped addr -> awvalid_o=0x20, push_dest_o=1, no error FSM entry.
//  6 rst asserted in SINK_W with out_cnt=3 -> next cycle all outputs 0, out_cnt 0; new mapped AW forwarded normally.

Source files
------------

// File: rtl/axi_aw_decoder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_aw_decoder_ctrl_if
// Brief    : AW/W/B handshake bundle around the AW address decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_aw_decoder_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int N_INIT_PORT = 8
);
    logic                   awvalid_i;
    logic [ADDR_WIDTH-1:0]  awaddr_i;
    logic                   awready_o;
    logic [N_INIT_PORT-1:0] awvalid_o;
    logic [N_INIT_PORT-1:0] awready_i;
    logic                   dest_ready_i;
    logic [N_INIT_PORT-1:0] dest_o;
    logic                   push_dest_o;
    logic                   b_done_i;
    logic                   wvalid_i;
    logic                   wlast_i;
    logic                   wready_err_o;
    logic                   err_bvalid_o;
    logic                   err_bready_i;

    // Decoder side
    modport slave (
        input  awvalid_i, awaddr_i, awready_i, dest_ready_i, b_done_i,
               wvalid_i, wlast_i, err_bready_i,
        output awready_o, awvalid_o, dest_o, push_dest_o, wready_err_o, err_bvalid_o
    );

    // Environment side (master AW, initiator ports, DEST FIFO, B tracker)
    modport master (
        output awvalid_i, awaddr_i, awready_i, dest_ready_i, b_done_i,
               wvalid_i, wlast_i, err_bready_i,
        input  awready_o, awvalid_o, dest_o, push_dest_o, wready_err_o, err_bvalid_o
    );
endinterface
`default_nettype wire

// File: rtl/axi_aw_decoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_aw_decoder_ctrl
// Brief    : AW-channel address decoder with outstanding-write tracking and
//            decode-error handling (drain, sink W, DECERR response).
// Revision : 1.0 - initial release
// ============================================================================
module axi_aw_decoder_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int N_INIT_PORT  = 8,
    parameter int N_REGION     = 2,
    parameter int MAX_OUT      = 8,
    parameter int ERR_MODE     = 0,
    parameter int DEFAULT_PORT = 0,
    localparam int CW          = $clog2(MAX_OUT + 1)
) (
    input  wire logic                                     clk,
    input  wire logic                                     rst,
    axi_aw_decoder_ctrl_if.slave                          bus,
    input  wire logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
    input  wire logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
    input  wire logic [N_REGION*N_INIT_PORT-1:0]          enable_region_i,
    input  wire logic [N_INIT_PORT-1:0]                   connectivity_map_i,
    output logic [CW-1:0]                                 out_cnt_o
);

    typedef enum logic [1:0] {
        S_OPERATIVE = 2'd0,
        S_DRAIN     = 2'd1,
        S_SINK_W    = 2'd2,
        S_ERR_RESP  = 2'd3
    } state_t;

    localparam logic [CW-1:0]          c_max_out      = CW'(MAX_OUT);
    localparam logic [N_INIT_PORT-1:0] c_default_dest = N_INIT_PORT'(1) << DEFAULT_PORT;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [CW-1:0]                   r_cnt;
    logic [CW-1:0]                   w_cnt_nxt;
    logic [N_REGION*N_INIT_PORT-1:0] w_region_hit;
    logic [N_INIT_PORT-1:0]          w_hit;
    logic [N_INIT_PORT-1:0]          w_masked;
    logic [N_INIT_PORT-1:0]          w_lowbit;
    logic [N_INIT_PORT-1:0]          w_dest;
    logic                            w_no_hit;
    logic                            w_err;
    logic                            w_go;
    logic                            w_dec;
    logic [N_INIT_PORT-1:0]          w_awvalid;
    logic                            w_awready;
    logic                            w_push;
    logic                            w_wready;
    logic                            w_bvalid;

    // Window index for port i, region r is i*N_REGION + r.
    for (genvar i = 0; i < N_INIT_PORT; i++) begin : g_port
        for (genvar r = 0; r < N_REGION; r++) begin : g_region
            localparam int c_idx = i * N_REGION + r;
            assign w_region_hit[c_idx] = enable_region_i[c_idx]
                && (start_addr_i[c_idx*ADDR_WIDTH +: ADDR_WIDTH] <= bus.awaddr_i)
                && (bus.awaddr_i <= end_addr_i[c_idx*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        assign w_hit[i] = |w_region_hit[i*N_REGION +: N_REGION];
    end

    // Isolating the lowest set bit gives lowest-index priority on overlaps.
    assign w_masked = w_hit & connectivity_map_i;
    assign w_lowbit = w_masked & (~w_masked + N_INIT_PORT'(1));
    assign w_no_hit = ~|w_masked;
    assign w_err    = w_no_hit && (ERR_MODE == 0);
    assign w_dest   = !w_no_hit ? w_lowbit : ((ERR_MODE != 0) ? c_default_dest : '0);

    assign w_go  = bus.awvalid_i && bus.dest_ready_i && (r_cnt < c_max_out);
    assign w_dec = bus.b_done_i && (r_cnt != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_awvalid   = '0;
        w_awready   = 1'b0;
        w_push      = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        case (r_state)
            S_OPERATIVE: begin
                if (w_go) begin
                    if (w_err) begin
                        w_awready   = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_awvalid = w_dest;
                        w_awready = |(bus.awready_i & w_dest);
                        w_push    = w_awready;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last outstanding B completes.
                if ((r_cnt == '0) || ((r_cnt == CW'(1)) && bus.b_done_i))
                    w_state_nxt = S_SINK_W;
            end
            S_SINK_W: begin
                w_wready = 1'b1;
                if (bus.wvalid_i && bus.wlast_i)
                    w_state_nxt = S_ERR_RESP;
            end
            S_ERR_RESP: begin
                w_bvalid = 1'b1;
                if (bus.err_bready_i)
                    w_state_nxt = S_OPERATIVE;
            end
            default: w_state_nxt = S_OPERATIVE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_dec)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (w_dec && !w_push)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OPERATIVE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are forced low while reset is asserted.
    assign bus.awvalid_o    = rst ? '0   : w_awvalid;
    assign bus.awready_o    = rst ? 1'b0 : w_awready;
    assign bus.push_dest_o  = rst ? 1'b0 : w_push;
    assign bus.dest_o       = rst ? '0   : w_dest;
    assign bus.wready_err_o = rst ? 1'b0 : w_wready;
    assign bus.err_bvalid_o = rst ? 1'b0 : w_bvalid;
    assign out_cnt_o        = rst ? '0   : r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_aw_decoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_aw_decoder_ctrl
// Brief    : Directed self-checking bench; dut0 ERR_MODE=0/MAX_OUT=2,
//            dut1 ERR_MODE=1/DEFAULT_PORT=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_aw_decoder_ctrl;
    localparam int AW = 32;
    localparam int NP = 8;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR*NP*AW-1:0] start_addr;
    logic [NR*NP*AW-1:0] end_addr;
    logic [NR*NP-1:0]    en_region;
    logic [NP-1:0]       conn_map;
    logic [1:0]          cnt0;
    logic [3:0]          cnt1;
    int                  n_cmp = 0;
    int                  n_err = 0;

    axi_aw_decoder_ctrl_if #(.ADDR_WIDTH(AW), .N_INIT_PORT(NP)) if0 ();
    axi_aw_decoder_ctrl_if #(.ADDR_WIDTH(AW), .N_INIT_PORT(NP)) if1 ();

    axi_aw_decoder_ctrl #(
        .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR),
        .MAX_OUT(2), .ERR_MODE(0), .DEFAULT_PORT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .enable_region_i(en_region), .connectivity_map_i(conn_map),
        .out_cnt_o(cnt0)
    );

    axi_aw_decoder_ctrl #(
        .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR),
        .MAX_OUT(8), .ERR_MODE(1), .DEFAULT_PORT(5)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .enable_region_i(en_region), .connectivity_map_i(conn_map),
        .out_cnt_o(cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.awvalid_i = 0; if0.awaddr_i = '0; if0.awready_i = '0; if0.dest_ready_i = 1;
        if0.b_done_i = 0; if0.wvalid_i = 0; if0.wlast_i = 0; if0.err_bready_i = 0;
        if1.awvalid_i = 0; if1.awaddr_i = '0; if1.awready_i = '0; if1.dest_ready_i = 1;
        if1.b_done_i = 0; if1.wvalid_i = 0; if1.wlast_i = 0; if1.err_bready_i = 0;
    endtask

    task automatic set_window(input int port, input int reg_n, input logic [AW-1:0] lo,
                              input logic [AW-1:0] hi, input logic ena);
        start_addr[(port*NR+reg_n)*AW +: AW] = lo;
        end_addr[(port*NR+reg_n)*AW +: AW]   = hi;
        en_region[port*NR+reg_n]             = ena;
    endtask

    task automatic test_reset();
        rst = 1;
        if0.awvalid_i = 1; if0.awaddr_i = 32'h1800; if0.awready_i = 8'hFF;
        if1.awvalid_i = 1; if1.awaddr_i = 32'hF000; if1.awready_i = 8'hFF;
        tick(); tick(); #2;
        n_cmp++; if (if0.awvalid_o !== 8'h00) begin n_err++; $display("FAIL rst_awvalid got=%h exp=00", if0.awvalid_o); end
        n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL rst_awready got=%b exp=0", if0.awready_o); end
        n_cmp++; if (if0.push_dest_o !== 1'b0) begin n_err++; $display("FAIL rst_push got=%b exp=0", if0.push_dest_o); end
        n_cmp++; if (if0.dest_o !== 8'h00) begin n_err++; $display("FAIL rst_dest got=%h exp=00", if0.dest_o); end
        n_cmp++; if (if0.wready_err_o !== 1'b0) begin n_err++; $display("FAIL rst_wready got=%b exp=0", if0.wready_err_o); end
        n_cmp++; if (if0.err_bvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_bvalid got=%b exp=0", if0.err_bvalid_o); end
        n_cmp++; if (cnt0 !== 2'd0) begin n_err++; $display("FAIL rst_cnt0 got=%0d exp=0", cnt0); end
        n_cmp++; if (if1.awvalid_o !== 8'h00) begin n_err++; $display("FAIL rst_awvalid1 got=%h exp=00", if1.awvalid_o); end
        rst = 0; idle();
        tick(); #2;
        n_cmp++; if (cnt0 !== 2'd0) begin n_err++; $display("FAIL rst_cnt0_after got=%0d exp=0", cnt0); end
        n_cmp++; if (cnt1 !== 4'd0) begin n_err++; $display("FAIL rst_cnt1_after got=%0d exp=0", cnt1); end
        tick();
    endtask

    task automatic test_forward();
        if0.awvalid_i = 1; if0.awaddr_i = 32'h1800; if0.awready_i = 8'h00; #2;
        n_cmp++; if (if0.awvalid_o !== 8'h04) begin n_err++; $display("FAIL fwd_wait_awvalid got=%h exp=04", if0.awvalid_o); end
        n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL fwd_wait_awready got=%b exp=0", if0.awready_o); end
        n_cmp++; if (if0.push_dest_o !== 1'b0) begin n_err++; $display("FAIL fwd_wait_push got=%b exp=0", if0.push_dest_o); end
        tick();
        if0.awready_i = 8'h04; #2;
        n_cmp++; if (if0.awvalid_o !== 8'h04) begin n_err++; $display("FAIL fwd_awvalid got=%h exp=04", if0.awvalid_o); end
        n_cmp++; if (if0.awready_o !== 1'b1) begin n_err++; $display("FAIL fwd_awready got=%b exp=1", if0.awready_o); end
        n_cmp++; if (if0.push_dest_o !== 1'b1) begin n_err++; $display("FAIL fwd_push got=%b exp=1", if0.push_dest_o); end
        n_cmp++; if (if0.dest_o !== 8'h04) begin n_err++; $display("FAIL fwd_dest got=%h exp=04", if0.dest_o); end
        n_cmp++; if (cnt0 !== 2'd0) begin n_err++; $display("FAIL fwd_cnt_before got=%0d exp=0", cnt0); end
        tick();
        if0.awvalid_i = 0; if0.awready_i = 8'h00; #2;
        n_cmp++; if (cnt0 !== 2'd1) begin n_err++; $display("FAIL fwd_cnt_after got=%0d exp=1", cnt0); end
        if0.b_done_i = 1; tick(); if0.b_done_i = 0; #2;
        n_cmp++; if (cnt0 !== 2'd0) begin n_err++; $display("FAIL fwd_cnt_bdone got=%0d exp=0", cnt0); end
        tick();
    endtask

    task automatic test_overlap();
        if0.awvalid_i = 1; if0.awready_i = 8'h00; if0.awaddr_i = 32'h2000; #2;
        n_cmp++; if (if0.dest_o !== 8'h02) begin n_err++; $display("FAIL ovl_dest got=%h exp=02", if0.dest_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h02) begin n_err++; $display("FAIL ovl_awvalid got=%h exp=02", if0.awvalid_o); end
        tick();
        conn_map = 8'hFD; #2;
        n_cmp++; if (if0.dest_o !== 8'h08) begin n_err++; $display("FAIL ovl_conn_dest got=%h exp=08", if0.dest_o); end
        tick();
        conn_map = 8'hFF; if0.awaddr_i = 32'h4FFF; #2;
        n_cmp++; if (if0.dest_o !== 8'h10) begin n_err++; $display("FAIL region1_dest got=%h exp=10", if0.dest_o); end
        tick();
        if0.awaddr_i = 32'h1FFF; #2;
        n_cmp++; if (if0.dest_o !== 8'h04) begin n_err++; $display("FAIL upper_edge_dest got=%h exp=04", if0.dest_o); end
        tick();
        if0.dest_ready_i = 0; if0.awready_i = 8'hFF; if0.awaddr_i = 32'h1000; #2;
        n_cmp++; if (if0.dest_o !== 8'h04) begin n_err++; $display("FAIL lower_edge_dest got=%h exp=04", if0.dest_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h00) begin n_err++; $display("FAIL destfull_awvalid got=%h exp=00", if0.awvalid_o); end
        n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL destfull_awready got=%b exp=0", if0.awready_o); end
        tick();
        if0.awaddr_i = 32'h0FFF; #2;
        n_cmp++; if (if0.dest_o !== 8'h00) begin n_err++; $display("FAIL below_window_dest got=%h exp=00", if0.dest_o); end
        tick();
        if0.awaddr_i = 32'hF800; #2;
        n_cmp++; if (if0.dest_o !== 8'h00) begin n_err++; $display("FAIL disabled_window_dest got=%h exp=00", if0.dest_o); end
        tick();
        idle(); tick();
    endtask

    task automatic test_max_out();
        if0.awvalid_i = 1; if0.awaddr_i = 32'h1800; if0.awready_i = 8'hFF; #2;
        n_cmp++; if (if0.awready_o !== 1'b1) begin n_err++; $display("FAIL max_aw1 got=%b exp=1", if0.awready_o); end
        tick(); #2;
        n_cmp++; if (if0.awready_o !== 1'b1) begin n_err++; $display("FAIL max_aw2 got=%b exp=1", if0.awready_o); end
        tick(); #2;
        n_cmp++; if (cnt0 !== 2'd2) begin n_err++; $display("FAIL max_cnt_full got=%0d exp=2", cnt0); end
        n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL max_stall_awready got=%b exp=0", if0.awready_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h00) begin n_err++; $display("FAIL max_stall_awvalid got=%h exp=00", if0.awvalid_o); end
        n_cmp++; if (if0.push_dest_o !== 1'b0) begin n_err++; $display("FAIL max_stall_push got=%b exp=0", if0.push_dest_o); end
        if0.b_done_i = 1; #2;
        n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL max_bdone_same got=%b exp=0", if0.awready_o); end
        tick();
        if0.b_done_i = 0; #2;
        n_cmp++; if (cnt0 !== 2'd1) begin n_err++; $display("FAIL max_cnt_dec got=%0d exp=1", cnt0); end
        n_cmp++; if (if0.push_dest_o !== 1'b1) begin n_err++; $display("FAIL max_accept_next got=%b exp=1", if0.push_dest_o); end
        tick();
        if0.awvalid_i = 0; if0.b_done_i = 1; tick();
        if0.awvalid_i = 1; #2;
        n_cmp++; if (if0.push_dest_o !== 1'b1) begin n_err++; $display("FAIL max_incdec_push got=%b exp=1", if0.push_dest_o); end
        tick();
        if0.awvalid_i = 0; #2;
        n_cmp++; if (cnt0 !== 2'd1) begin n_err++; $display("FAIL max_incdec_cnt got=%0d exp=1", cnt0); end
        tick(); tick(); #2;
        n_cmp++; if (cnt0 !== 2'd0) begin n_err++; $display("FAIL max_no_wrap got=%0d exp=0", cnt0); end
        idle(); tick();
    endtask

    task automatic test_decode_error();
        if0.awvalid_i = 1; if0.awaddr_i = 32'h1800; if0.awready_i = 8'hFF; tick();
        if0.awaddr_i = 32'hF000; #2;
        n_cmp++; if (if0.awready_o !== 1'b1) begin n_err++; $display("FAIL err_awready got=%b exp=1", if0.awready_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h00) begin n_err++; $display("FAIL err_awvalid got=%h exp=00", if0.awvalid_o); end
        n_cmp++; if (if0.push_dest_o !== 1'b0) begin n_err++; $display("FAIL err_push got=%b exp=0", if0.push_dest_o); end
        n_cmp++; if (if0.dest_o !== 8'h00) begin n_err++; $display("FAIL err_dest got=%h exp=00", if0.dest_o); end
        tick();
        if0.awaddr_i = 32'h1800;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL drain_awready%0d got=%b exp=0", k, if0.awready_o); end
            n_cmp++; if (if0.wready_err_o !== 1'b0) begin n_err++; $display("FAIL drain_wready%0d got=%b exp=0", k, if0.wready_err_o); end
            n_cmp++; if (cnt0 !== 2'd1) begin n_err++; $display("FAIL drain_cnt%0d got=%0d exp=1", k, cnt0); end
            tick();
        end
        if0.b_done_i = 1; tick();
        if0.b_done_i = 0; if0.awvalid_i = 0;
        for (int b = 0; b < 5; b++) begin
            if0.wvalid_i = (b != 1);
            if0.wlast_i  = (b == 4);
            #2;
            n_cmp++; if (if0.wready_err_o !== 1'b1) begin n_err++; $display("FAIL sink_wready%0d got=%b exp=1", b, if0.wready_err_o); end
            n_cmp++; if (if0.err_bvalid_o !== 1'b0) begin n_err++; $display("FAIL sink_bvalid%0d got=%b exp=0", b, if0.err_bvalid_o); end
            tick();
        end
        if0.wvalid_i = 0; if0.wlast_i = 0; if0.awvalid_i = 1;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_cmp++; if (if0.err_bvalid_o !== 1'b1) begin n_err++; $display("FAIL resp_bvalid%0d got=%b exp=1", k, if0.err_bvalid_o); end
            n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL resp_awready%0d got=%b exp=0", k, if0.awready_o); end
            tick();
        end
        if0.err_bready_i = 1; tick();
        if0.err_bready_i = 0; #2;
        n_cmp++; if (if0.err_bvalid_o !== 1'b0) begin n_err++; $display("FAIL resp_done_bvalid got=%b exp=0", if0.err_bvalid_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h04) begin n_err++; $display("FAIL resp_done_awvalid got=%h exp=04", if0.awvalid_o); end
        tick();
        if0.awvalid_i = 0; if0.b_done_i = 1; tick();
        idle(); tick();
    endtask

    task automatic test_default_port();
        if1.awvalid_i = 1; if1.awaddr_i = 32'hF000; if1.awready_i = 8'hFF; #2;
        n_cmp++; if (if1.awvalid_o !== 8'h20) begin n_err++; $display("FAIL dflt_awvalid got=%h exp=20", if1.awvalid_o); end
        n_cmp++; if (if1.dest_o !== 8'h20) begin n_err++; $display("FAIL dflt_dest got=%h exp=20", if1.dest_o); end
        n_cmp++; if (if1.push_dest_o !== 1'b1) begin n_err++; $display("FAIL dflt_push got=%b exp=1", if1.push_dest_o); end
        tick();
        if1.awvalid_i = 0; #2;
        n_cmp++; if (if1.wready_err_o !== 1'b0) begin n_err++; $display("FAIL dflt_wready got=%b exp=0", if1.wready_err_o); end
        n_cmp++; if (cnt1 !== 4'd1) begin n_err++; $display("FAIL dflt_cnt got=%0d exp=1", cnt1); end
        tick();
        if1.awvalid_i = 1; if1.awaddr_i = 32'h1800; if1.awready_i = 8'h04; #2;
        n_cmp++; if (if1.awvalid_o !== 8'h04) begin n_err++; $display("FAIL dflt_next_awvalid got=%h exp=04", if1.awvalid_o); end
        tick();
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        if1.awvalid_i = 1; if1.awaddr_i = 32'hF000; if1.awready_i = 8'hFF;
        if0.awvalid_i = 1; if0.awaddr_i = 32'hF000; tick();
        if1.awvalid_i = 0; if0.awvalid_i = 0; tick(); #2;
        n_cmp++; if (if0.wready_err_o !== 1'b1) begin n_err++; $display("FAIL mid_in_sink got=%b exp=1", if0.wready_err_o); end
        n_cmp++; if (cnt1 !== 4'd3) begin n_err++; $display("FAIL mid_cnt1_pre got=%0d exp=3", cnt1); end
        tick();
        rst = 1; if0.awvalid_i = 1; if0.awaddr_i = 32'h1800; if0.awready_i = 8'hFF; if0.wvalid_i = 1; #2;
        n_cmp++; if (if0.wready_err_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_wready got=%b exp=0", if0.wready_err_o); end
        n_cmp++; if (if0.awready_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_awready got=%b exp=0", if0.awready_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h00) begin n_err++; $display("FAIL mid_rst_awvalid got=%h exp=00", if0.awvalid_o); end
        n_cmp++; if (cnt1 !== 4'd0) begin n_err++; $display("FAIL mid_rst_cnt1 got=%0d exp=0", cnt1); end
        tick();
        rst = 0; if0.wvalid_i = 0; #2;
        n_cmp++; if (if0.wready_err_o !== 1'b0) begin n_err++; $display("FAIL mid_post_wready got=%b exp=0", if0.wready_err_o); end
        n_cmp++; if (if0.awvalid_o !== 8'h04) begin n_err++; $display("FAIL mid_post_awvalid got=%h exp=04", if0.awvalid_o); end
        n_cmp++; if (if0.push_dest_o !== 1'b1) begin n_err++; $display("FAIL mid_post_push got=%b exp=1", if0.push_dest_o); end
        n_cmp++; if (cnt1 !== 4'd0) begin n_err++; $display("FAIL mid_post_cnt1 got=%0d exp=0", cnt1); end
        tick();
        if0.awvalid_i = 0; #2;
        n_cmp++; if (cnt0 !== 2'd1) begin n_err++; $display("FAIL mid_post_cnt0 got=%0d exp=1", cnt0); end
        idle(); tick();
    endtask

    initial begin
        start_addr = '0; end_addr = '0; en_region = '0; conn_map = 8'hFF;
        set_window(2, 0, 32'h1000, 32'h1FFF, 1'b1);
        set_window(1, 0, 32'h2000, 32'h2FFF, 1'b1);
        set_window(3, 0, 32'h2000, 32'h20FF, 1'b1);
        set_window(4, 1, 32'h4000, 32'h4FFF, 1'b1);
        set_window(6, 0, 32'hF800, 32'hFFFF, 1'b0);
        idle();
        test_reset();
        test_forward();
        test_overlap();
        test_max_out();
        test_decode_error();
        test_default_port();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
